pwm_gen: RTL and testbench
==========================

# pwm_gen

Single-channel PWM generator that turns an 8-bit level into a fixed-period pulse train for one LED colour. It sits directly downstream of the rotary `encoder` stage in `top`, and its `level` input is driven by that stage's `value` output. Three instances (R, G, B) are planned. Duty is double-buffered: a new level takes effect only at a period boundary, so output pulses are never torn.

## Interface
- `width`, default 8: bit width of `level` and of the period counter.
- `prescale`, default 1: clock cycles per counter tick. Must be ≥ 1; 1 means no division.
- `invert`, default 0: when 1, `out` is the complement of the PWM waveform. Does not apply to `period_start`.
- `clk` input, 1 bit: system clock. All state is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clears all state immediately.
- `level` input, `width` bits: requested duty. Sampled only at a period boundary; may change on any cycle.
- `out` output, 1 bit: registered PWM output.
- `period_start` output, 1 bit: one-`clk` pulse marking the first cycle of each new period.

## Operation
- Let `MAX = 2^width - 1`, which is 255 for the default width.

Prescaler:
- `pre` counts from 0 to `prescale-1`, then wraps.
- `tick = (pre == prescale-1)`. With `prescale = 1`, `tick` is high every cycle.

Period counter:
- On `tick`, `cnt` advances 0, 1, …, MAX-1, then wraps to 0.
- One period is MAX ticks (255 for the default width).
- `cnt` never holds the value MAX.

Duty shadow register `duty`:
- Loaded with `level` on the `tick` where `cnt == MAX-1`, which is the same edge on which `cnt` wraps to 0.
- Held constant for the whole period.

Compare:
- `out` is registered every `clk` as `(cnt < duty) ^ invert`.
- `duty = 0` gives `out` constantly at `invert`.
- `duty = MAX` gives `out` constantly at `!invert`; 100 % duty is reachable.
- `duty = k` gives exactly k high ticks per period (non-inverted).

`period_start`:
- Registered.
- High for exactly one `clk`, in the cycle after the wrap edge.
- Aligned with the first `out` value of the new period.

Reset (asynchronous, takes effect immediately, including mid-period):
- `pre = 0`, `cnt = 0`, `duty = 0`.
- `out = invert`, `period_start = 0`.

After reset:
- The first period runs with `duty = 0`.
- `level` is first sampled at the end of that first period.

Simultaneous events:
- A `level` change on the wrap edge is captured by that load.
- A `level` change on any other edge is ignored until the next wrap.

## Timing
- Latency from `cnt`/`duty` to `out`: 1 `clk`.
- Period length: `prescale * MAX` clk. For the defaults this is 255 clk.
- `out` high time per period: `prescale * duty` clk (non-inverted), contiguous, starting at `period_start`.
- Worst-case latency from a `level` change to its first effect on `out`:
  - one full period plus 1 clk, when the change arrives just after a wrap;
  - otherwise up to the next boundary plus 1 clk.
- First `period_start` after reset release: at clk `prescale * MAX + 1`, counting from the first rising edge after release.
- No handshake. `level` is treated as a level signal, synchronous to `clk`.

## Structure
- No shared package is required. `MAX` is a local constant derived from `width`.
- The prescaler is a natural sub-module: `tick_gen` (parameter `prescale`; ports `clk`, `reset`, `tick`).
  - It is reused later for the debounce sample strobe.
  - When `prescale == 1`, it ties `tick` high and removes the counter.
- Integration in `top`: `pwm_gen #(.width(8)) pwm_r(.clk(clk), .reset(reset), .level(encoder), .out(...))`.

## Test plan
All scenarios use `width = 8`, `prescale = 1`, `invert = 0` unless stated.

1. **Reset state.** Assert reset mid-period with `level = 100`. Expect `out = 0` and `period_start = 0` immediately, without waiting for a clock edge. After release, `out` stays 0 for the first 255 clk, and `period_start` first pulses at clk 256.
2. **Steady duty.** Hold `level = 64`. From the second period on, expect `period_start` every 255 clk. `out` is high for 64 clk starting with the `period_start` cycle, then low for 191 clk.
3. **Extremes.**
   - `level = 0`: `out` is never high across 3 periods.
   - `level = 255`: `out` is always high across 3 periods.
   - `period_start` still pulses every 255 clk in both cases.
4. **Glitch-free update.** With `level = 64` steady, change `level` to 200 at clk 30 of a period. The current period still has 64 high clk; the next period has 200 high clk. A change applied exactly on the wrap edge takes effect in the very next period.
5. **Prescale and invert.** Set `prescale = 4`, `invert = 1`, `level = 64`. Expect a period of 1020 clk, with `out` low for 256 clk then high for 764 clk. `period_start` is active-high and uninverted.

Source files
------------

// File: rtl/pwm_gen_pkg.sv
// -----------------------------------------------------------------------------
// pwm_gen_pkg
//
// Purpose : Shared defaults and elaboration-time helpers for the PWM
//           generator and its tick prescaler.
//
// Contents:
//   PWM_DEFAULT_WIDTH    - default bit width of the level / period counter
//   PWM_DEFAULT_PRESCALE - default clocks per counter tick (1 = no division)
//   pwm_max()            - largest counter value for a given width (2^w - 1)
//   tick_cnt_width()     - bits needed for a prescale counter, never below 1
// -----------------------------------------------------------------------------
package pwm_gen_pkg;

    localparam int unsigned PWM_DEFAULT_WIDTH    = 8;
    localparam int unsigned PWM_DEFAULT_PRESCALE = 1;

    // All-ones value for a counter of w bits; one period lasts this many ticks.
    function automatic int unsigned pwm_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Width of a counter that must hold 0 .. n-1.
    function automatic int unsigned tick_cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : pwm_gen_pkg

// File: rtl/pwm_gen_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Purpose : Clock-enable strobe generator. Divides clk by `prescale` and
//           asserts `tick` for one cycle out of every `prescale`. Also meant
//           for the debounce sample strobe.
//
// Parameters:
//   prescale - clocks per tick, >= 1. A value of 1 ties tick high and
//              removes the counter entirely.
//
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous, active-high; restarts the divider at 0
//   tick  out combinational strobe, high while the divider sits on its last
//             count (pre == prescale-1)
// -----------------------------------------------------------------------------
module tick_gen
    import pwm_gen_pkg::*;
#(
    parameter int unsigned prescale = PWM_DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    if (prescale <= 1) begin : g_bypass

        // No division: every clock is a tick. clk and reset are still ports
        // so all instances share one interface.
        logic unused_inputs;
        assign unused_inputs = clk ^ reset;
        assign tick          = 1'b1;

    end else begin : g_divider

        localparam int unsigned PW = tick_cnt_width(prescale);
        localparam logic [PW-1:0] PRE_LAST = PW'(prescale - 1);

        logic [PW-1:0] pre_q;
        logic [PW-1:0] pre_d;

        // NOTE: every always_comb output gets a default on its first line, so
        // no path through the block can leave it unassigned and infer a latch.
        always_comb begin
            pre_d = pre_q + 1'b1;
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
            end
        end

        // NOTE: state registers use non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_d;
            end
        end

        assign tick = (pre_q == PRE_LAST);

    end

endmodule : tick_gen

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
//
// Purpose : Single-channel, double-buffered PWM generator for one LED colour.
//           A free-running period counter is compared against a duty shadow
//           register that is reloaded from `level` only at the period
//           boundary, so a pulse is never torn by a mid-period level change.
//
// Parameters:
//   width    - bits of `level` and of the period counter (MAX = 2^width - 1)
//   prescale - clocks per counter tick, >= 1 (1 = no division)
//   invert   - 1 complements `out`; `period_start` is never inverted
//
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  asynchronous, active-high; clears all state at once
//   level        in  requested duty, sampled only on the wrap tick
//   out          out registered PWM output, (cnt < duty) ^ invert
//   period_start out registered one-clk pulse on the first output cycle of
//                    every period
//
// Timing (prescale = P):
//   period = P * MAX clk, high time = P * duty clk starting with the
//   period_start cycle, first period_start at clk P * MAX + 1 after reset.
// -----------------------------------------------------------------------------
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int unsigned width    = PWM_DEFAULT_WIDTH,
    parameter int unsigned prescale = PWM_DEFAULT_PRESCALE,
    parameter bit          invert   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] level,
    output logic             out,
    output logic             period_start
);

    // MAX itself is never held by the counter, which makes duty = MAX give a
    // compare that is true on every tick (100 % duty).
    localparam logic [width-1:0] MAX      = width'(pwm_max(width));
    localparam logic [width-1:0] CNT_LAST = MAX - 1'b1;

    logic             tick;
    logic             wrap;

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;
    logic [width-1:0] duty_q;
    logic [width-1:0] duty_d;
    logic             wrap_q;
    logic             out_q;
    logic             out_d;
    logic             period_start_q;
    logic             period_start_d;

    // -------------------------------------------------------------------------
    // Tick prescaler
    // -------------------------------------------------------------------------
    tick_gen #(
        .prescale (prescale)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // The wrap tick ends a period: the counter returns to 0 and the shadow
    // duty is reloaded on the same edge, so the new period starts with a
    // consistent (cnt, duty) pair.
    assign wrap = tick && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d  = cnt_q;
        duty_d = duty_q;
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (wrap) begin
            cnt_d  = '0;
            duty_d = level;
        end
    end

    // out is one clk behind (cnt, duty). period_start is delayed through
    // wrap_q by the same amount so it lines up with the first out value of
    // the new period rather than with the counter reload.
    always_comb begin
        out_d          = (cnt_q < duty_q) ^ invert;
        period_start_d = wrap_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            duty_q         <= '0;
            wrap_q         <= 1'b0;
            out_q          <= invert;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            wrap_q         <= wrap;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen
//
// Two instances run side by side on one clock and reset:
//   dut_a : width 8, prescale 1, non-inverted
//   dut_b : width 8, prescale 4, inverted
// Expected outputs come from a closed-form model: after m edges since reset
// release the tick count is m / P, the counter is (ticks mod MAX) and the
// period index is (ticks / MAX). Each period's duty is the level present at
// the edge that closed the previous period (0 for the first period).
// -----------------------------------------------------------------------------
module tb_pwm_gen;

    localparam int MAX = 255;
    localparam int PA  = 1;
    localparam int PB  = 4;
    localparam int NP  = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] level_a;
    logic [7:0] level_b;
    logic       out_a;
    logic       ps_a;
    logic       out_b;
    logic       ps_b;

    int checks   = 0;
    int failures = 0;

    // Model state.
    int n;              // rising edges since reset release
    int duty_a [NP];    // duty in force during each period of dut_a
    int duty_b [NP];
    int hi_a, hi_b;     // high clocks observed in the current period window
    int exp_hi_a, exp_hi_b;
    bit win_a, win_b;   // a full period window is being measured

    pwm_gen #(
        .width    (8),
        .prescale (PA),
        .invert   (1'b0)
    ) dut_a (
        .clk          (clk),
        .reset        (reset),
        .level        (level_a),
        .out          (out_a),
        .period_start (ps_a)
    );

    pwm_gen #(
        .width    (8),
        .prescale (PB),
        .invert   (1'b1)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .level        (level_b),
        .out          (out_b),
        .period_start (ps_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int period_duty(input int which, input int p);
        if (p <= 0 || p >= NP) return 0;
        return (which == 0) ? duty_a[p] : duty_b[p];
    endfunction

    // Output value visible after edge m+1, i.e. derived from the state after m edges.
    function automatic logic exp_out(input int which, input int m);
        int p_s, ticks, cnt, per;
        bit inv;
        p_s   = (which == 0) ? PA : PB;
        inv   = (which != 0);
        ticks = m / p_s;
        cnt   = ticks % MAX;
        per   = ticks / MAX;
        return logic'((cnt < period_duty(which, per)) ^ inv);
    endfunction

    function automatic logic exp_ps(input int which, input int m);
        int len;
        len = ((which == 0) ? PA : PB) * MAX;
        return logic'((m > 0) && (m % len == 0));
    endfunction

    // One clock: record any level captured on this edge, then check both DUTs
    // on the falling edge.
    task automatic step();
        int pa_len, pb_len, per;
        pa_len = PA * MAX;
        pb_len = PB * MAX;
        @(posedge clk);
        n++;
        if (n % pa_len == 0 && n / pa_len < NP) duty_a[n / pa_len] = int'(level_a);
        if (n % pb_len == 0 && n / pb_len < NP) duty_b[n / pb_len] = int'(level_b);
        @(negedge clk);
        check("outA", out_a, exp_out(0, n - 1));
        check("psA",  ps_a,  exp_ps(0, n - 1));
        check("outB", out_b, exp_out(1, n - 1));
        check("psB",  ps_b,  exp_ps(1, n - 1));

        if (exp_ps(0, n - 1)) begin
            if (win_a) check("highA", hi_a, exp_hi_a);
            per      = (n - 1) / pa_len;
            win_a    = 1'b1;
            hi_a     = 0;
            exp_hi_a = period_duty(0, per) * PA;
        end
        if (out_a === 1'b1) hi_a++;

        if (exp_ps(1, n - 1)) begin
            if (win_b) check("highB", hi_b, exp_hi_b);
            per      = (n - 1) / pb_len;
            win_b    = 1'b1;
            hi_b     = 0;
            exp_hi_b = pb_len - period_duty(1, per) * PB;
        end
        if (out_b === 1'b1) hi_b++;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Advance dut_a until its counter (n mod MAX) reaches ph; at most MAX steps.
    task automatic run_to_phase(input int ph);
        for (int i = 0; i < MAX && (n % MAX) != ph; i++) step();
    endtask

    // Called just after a falling edge: assert reset between edges and check
    // that the outputs change without waiting for a clock.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rstAsyncOutA", out_a, 1'b0);
        check("rstAsyncPsA",  ps_a,  1'b0);
        check("rstAsyncOutB", out_b, 1'b1);
        check("rstAsyncPsB",  ps_b,  1'b0);
        @(posedge clk);
        @(negedge clk);
        check("rstHoldOutA", out_a, 1'b0);
        check("rstHoldOutB", out_b, 1'b1);
        reset = 1'b0;
        n     = 0;
        for (int i = 0; i < NP; i++) begin
            duty_a[i] = 0;
            duty_b[i] = 0;
        end
        win_a = 1'b0;
        win_b = 1'b0;
        hi_a  = 0;
        hi_b  = 0;
    endtask

    initial begin
        reset   = 1'b0;
        level_a = 8'd100;
        level_b = 8'd64;
        n       = 0;
        @(negedge clk);
        do_reset();

        // Reset state: run into a period, then reset mid-period with level 100.
        run(100);
        do_reset();
        // First period after release runs at duty 0; level 100 is picked up
        // at its end.
        run(MAX + 10);

        // Steady duty 64.
        level_a = 8'd64;
        run(2 * MAX);

        // Extremes.
        level_a = 8'd0;
        run_to_phase(0);
        run(3 * MAX + 2);
        level_a = 8'd255;
        run(4 * MAX);

        // Glitch-free update: change at clk 30 of a period.
        level_a = 8'd64;
        run(MAX);
        run_to_phase(30);
        level_a = 8'd200;
        run(2 * MAX);

        // Change presented on the wrap edge is captured; the next change is not.
        run_to_phase(MAX - 1);
        level_a = 8'd17;
        step();
        level_a = 8'd99;
        run(300);

        // Randomised levels changing at random points in the period.
        for (int i = 0; i < 40; i++) begin
            level_a = 8'($urandom_range(0, 255));
            level_b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) level_a = 8'd255;
            if ($urandom_range(0, 7) == 0) level_a = 8'd0;
            run(int'($urandom_range(1, 120)));
        end
        run(PB * MAX + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pwm_gen
